led_scan_ctrl: RTL and testbench
================================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clk cycles between digit-scan steps (legal 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inc  input  1  single-cycle request to increment displayed BCD count by one.
REQ-005 SHALL have port wr_valid  input  1  load request for count buffer.
REQ-006 SHALL have port wr_data  input  32  eight BCD digits, digit 0 in bits [3:0].
REQ-007 SHALL have port wr_ready  output  1  load accepted when wr_valid and wr_ready both high.
REQ-008 SHALL have port count  output  32  current count buffer.
REQ-009 SHALL have port ovf  output  1  one-cycle pulse when count wraps 99999999 -> 00000000.
REQ-010 SHALL have port enable  output  1  one-cycle strobe to display driver.
REQ-011 SHALL have port sidx  output  3  digit position for the strobe.
REQ-012 SHALL have port val  output  4  digit code for the strobe; 4'hF = blank.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap; enable SHALL be high exactly in the cycle after the prescaler holds CLK_DIV-1.
REQ-014 sidx and val SHALL be registered and change only in the cycle enable is high; they hold otherwise.
REQ-015 Scan pointer SHALL present 0,1,...,7,0,... on successive enable strobes; val = buffer digit[sidx] as of the prescaler terminal cycle.
REQ-016 Control FSM SHALL have states IDLE and INC; wr_ready = 1 only in IDLE.
REQ-017 IDLE: wr_valid -> buffer <= wr_data next cycle, stay IDLE; else inc -> latch digit pointer k=0, go INC.
REQ-018 IDLE with wr_valid and inc in same cycle: write SHALL win, inc SHALL be dropped.
REQ-019 INC: if digit[k] >= 9, digit[k] <= 0 and k <= k+1 (carry, one digit per cycle); else digit[k] <= digit[k]+1, go IDLE.
REQ-020 INC with k = 7 and digit[7] >= 9: digit[7] <= 0, ovf pulses that cycle, go IDLE.
REQ-021 inc asserted during INC SHALL set a single pending flag; IDLE with pending set SHALL start INC next and clear flag; further incs while flag set are dropped.
REQ-022 wr_data digits > 9 SHALL be stored unmodified; scanning presents them raw (driver blanks them).
REQ-023 Scan SHALL run independently of FSM; intermediate carry values may be displayed.

Reset
REQ-024 rst_n low SHALL immediately force: FSM IDLE, pending 0, count 0, prescaler 0, scan pointer 0, enable 0, sidx 0, val 0, ovf 0, wr_ready 1.
REQ-025 Reset mid-INC SHALL abandon the carry; no ovf pulse.
REQ-026 First enable after rst_n rises SHALL occur CLK_DIV cycles later with sidx 0.

Configuration
REQ-027 Macro LED_SCAN_ZERO_BLANK_EN defined: val SHALL be 4'hF for any digit position above the most significant nonzero digit; position 0 never blanked.
REQ-028 Macro undefined: val SHALL always be raw buffer digit; no blanking logic present.

Structure
REQ-029 Package led_scan_pkg SHALL hold NUM_DIGITS=8, BLANK_CODE=4'hF, BCD digit typedef, FSM state enum.
REQ-030 Prescaler plus scan pointer SHALL be sub-module led_scan_tick (outputs tick and pointer).

Verification
REQ-031 CLK_DIV=4, reset release -> enable high at cycles 4,8,12...; sidx 0,1,2...,7,0.
REQ-032 Load 00000019, single inc -> FSM INC 2 cycles, count 00000020, wr_ready low those 2 cycles.
REQ-033 Load 99999999, inc -> 8 INC cycles, count 00000000, ovf single pulse on 8th.
REQ-034 wr_valid and inc same IDLE cycle with wr_data 00000005 -> count 00000005, no increment; three incs during one long carry -> exactly one extra increment.
REQ-035 With LED_SCAN_ZERO_BLANK_EN, count 00000305 -> val F,F,F,F,F,3,0,5 for sidx 7..0; without macro -> 0,0,0,0,0,3,0,5.
REQ-036 rst_n low mid-carry from 99999999 -> all outputs at reset values immediately, ovf never pulses.

Source files
------------

// File: rtl/led_scan_pkg.sv
// led_scan_pkg -- shared constants and types for the LED scan controller.
//   NUM_DIGITS : digits held in the count buffer and scanned by the display
//   BLANK_CODE : digit code the display driver renders as an unlit digit
//   bcd_t      : one BCD digit (codes above 9 may be loaded and are kept raw)
//   state_e    : control FSM states
package led_scan_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INC  = 1'b1
    } state_e;

endpackage

// File: rtl/led_scan_tick.sv
// led_scan_tick -- scan prescaler and digit pointer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   tick       : high during the prescaler terminal cycle (count == CLK_DIV-1)
//   ptr        : digit position to present on the next display strobe
// The pointer advances on every terminal cycle, so the position sampled in a
// terminal cycle is the one shown by the strobe that follows it.
module led_scan_tick
    import led_scan_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [2:0] ptr
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    ptr_q, ptr_d;

    always_comb begin
        tick  = (pre_q == LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
        ptr_d = tick ? ptr_q + 3'd1 : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ptr_q <= '0;
        end else begin
            pre_q <= pre_d;
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl -- 8-digit BCD counter with multiplexed display scan.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   inc                : one-cycle request to add one to the BCD count
//   wr_valid/wr_ready  : load handshake for wr_data (8 BCD digits, digit 0 LSBs)
//   count              : current count buffer
//   ovf                : one-cycle pulse when the count wraps 99999999 -> 0
//   enable, sidx, val  : display strobe, digit position and digit code
// Optional feature macro LED_SCAN_ZERO_BLANK_EN: leading zeros above the most
// significant nonzero digit are shown as BLANK_CODE (digit 0 is always shown).
// The increment ripples one digit per cycle in ST_INC; the scan keeps running
// meanwhile, so partially carried values can appear on the display.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic [31:0] count,
    output logic        ovf,
    output logic        enable,
    output logic [2:0]  sidx,
    output logic [3:0]  val
);

    state_e                       state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]   count_q, count_d;
    logic [2:0]                   k_q, k_d;
    logic                         pend_q, pend_d;
    logic                         enable_q, enable_d;
    logic [2:0]                   sidx_q, sidx_d;
    bcd_t                         val_q, val_d;

    logic       tick;
    logic [2:0] ptr;
    bcd_t       cur;
    bcd_t       scan_digit;

    led_scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .ptr   (ptr)
    );

    // Control FSM: loads, increment start and digit-serial carry.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        pend_d  = pend_q;
        ovf     = 1'b0;
        cur     = count_q[k_q];
        case (state_q)
            ST_IDLE: begin
                // A load takes priority; an inc in the same cycle is dropped.
                if (wr_valid) begin
                    count_d = wr_data;
                end else if (pend_q || inc) begin
                    k_d     = 3'd0;
                    pend_d  = 1'b0;
                    state_d = ST_INC;
                end
            end
            ST_INC: begin
                // Only one request is remembered while a carry is in flight.
                if (inc) pend_d = 1'b1;
                if (cur >= 4'd9) begin
                    count_d[k_q] = 4'd0;
                    if (k_q == 3'(NUM_DIGITS - 1)) begin
                        ovf     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else begin
                    count_d[k_q] = cur + 4'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LED_SCAN_ZERO_BLANK_EN
    // Blank a position when it and every digit above it are zero.
    logic nz;
    always_comb begin
        nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (3'(j) >= ptr && count_q[j] != 4'd0) nz = 1'b1;
        end
        scan_digit = (ptr == 3'd0 || nz) ? count_q[ptr] : BLANK_CODE;
    end
`else
    always_comb begin
        scan_digit = count_q[ptr];
    end
`endif

    // Display strobe follows the terminal cycle; position/code captured then.
    always_comb begin
        enable_d = tick;
        sidx_d   = tick ? ptr : sidx_q;
        val_d    = tick ? scan_digit : val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            k_q      <= '0;
            pend_q   <= 1'b0;
            enable_q <= 1'b0;
            sidx_q   <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            k_q      <= k_d;
            pend_q   <= pend_d;
            enable_q <= enable_d;
            sidx_q   <= sidx_d;
            val_q    <= val_d;
        end
    end

    assign wr_ready = (state_q == ST_IDLE);
    assign count    = count_q;
    assign enable   = enable_q;
    assign sidx     = sidx_q;
    assign val      = val_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl -- scoreboard bench for led_scan_ctrl with CLK_DIV = 4.
// Scan expectations (strobe cycle, position, code) and per-operation
// expectations (final count, busy cycles, ovf pulses) are queued when the
// stimulus is driven and popped when the DUT produces the matching output.
module tb_led_scan_ctrl;

    localparam int CLK_DIV = 4;
`ifdef LED_SCAN_ZERO_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic        clk, rst_n, inc, wr_valid, wr_ready, ovf, enable;
    logic [31:0] wr_data, count;
    logic [2:0]  sidx;
    logic [3:0]  val;

    led_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .count    (count),
        .ovf      (ovf),
        .enable   (enable),
        .sidx     (sidx),
        .val      (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] sidx;
        logic [3:0] val;
    } scan_exp_t;

    typedef struct {
        logic [31:0] cnt;
        int          busy;
        int          ovfs;
        int          ovf_at;
    } op_exp_t;

    scan_exp_t scan_q[$];
    op_exp_t   op_q[$];
    int        n_chk = 0;
    int        n_err = 0;
    int        cyc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scan monitor: each strobe consumes one queued expectation, if any.
    always @(negedge clk) begin
        scan_exp_t e;
        if (rst_n && enable && scan_q.size() > 0) begin
            e = scan_q.pop_front();
            chk("scan_cyc",  cyc,  e.cyc);
            chk("scan_sidx", sidx, e.sidx);
            chk("scan_val",  val,  e.val);
        end
    end

    // Expected strobes after a reset release, given the buffer contents.
    task automatic push_scan(input logic [31:0] cnt, input int n);
        scan_exp_t e;
        logic [31:0] above;
        for (int i = 0; i < n; i++) begin
            e.cyc  = CLK_DIV * (i + 1);
            e.sidx = 3'(i % 8);
            e.val  = cnt[(i % 8) * 4 +: 4];
            above  = cnt >> (4 * (i % 8));
            if (BLANK_ON && (i % 8) != 0 && above == 32'd0) e.val = 4'hF;
            scan_q.push_back(e);
        end
    endtask

    task automatic push_op(input logic [31:0] cnt, input int busy, input int ovfs, input int ovf_at);
        op_exp_t e;
        e.cnt = cnt; e.busy = busy; e.ovfs = ovfs; e.ovf_at = ovf_at;
        op_q.push_back(e);
    endtask

    task automatic load(input logic [31:0] d, input logic with_inc);
        wr_valid = 1'b1;
        wr_data  = d;
        inc      = with_inc;
        @(negedge clk);
        wr_valid = 1'b0;
        inc      = 1'b0;
    endtask

    // Run ncyc cycles driving inc from mask, then compare against op_q head.
    task automatic observe(input string tag, input logic [31:0] mask, input int ncyc);
        int busy, ovfs, ovf_at;
        op_exp_t e;
        busy = 0; ovfs = 0; ovf_at = 0;
        for (int i = 0; i < ncyc; i++) begin
            inc = mask[i];
            @(negedge clk);
            if (!wr_ready) busy++;
            if (ovf) begin
                ovfs++;
                ovf_at = busy;
            end
        end
        inc = 1'b0;
        if (op_q.size() == 0) begin
            chk({tag, "_no_exp"}, 32'd1, 32'd0);
        end else begin
            e = op_q.pop_front();
            chk({tag, "_count"},  count,  e.cnt);
            chk({tag, "_busy"},   busy,   e.busy);
            chk({tag, "_ovfs"},   ovfs,   e.ovfs);
            chk({tag, "_ovf_at"}, ovf_at, e.ovf_at);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_count"},    count,    32'd0);
        chk({tag, "_wr_ready"}, wr_ready, 32'd1);
        chk({tag, "_enable"},   enable,   32'd0);
        chk({tag, "_sidx"},     sidx,     32'd0);
        chk({tag, "_val"},      val,      32'd0);
        chk({tag, "_ovf"},      ovf,      32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        inc      = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        #3;
        chk_reset_outs("rst0");

        // Scan order and strobe timing from an all-zero buffer.
        push_scan(32'h0000_0000, 9);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Two-digit carry.
        push_op(32'h0000_0020, 2, 0, 0);
        load(32'h0000_0019, 1'b0);
        observe("inc19", 32'h1, 10);

        // Full wrap.
        push_op(32'h0000_0000, 8, 1, 8);
        load(32'h9999_9999, 1'b0);
        observe("wrap", 32'h1, 20);

        // Load and inc together: load wins.
        push_op(32'h0000_0005, 0, 0, 0);
        load(32'h0000_0005, 1'b1);
        observe("wr_inc", 32'h0, 6);

        // Three incs during a long carry give one extra increment.
        push_op(32'h0000_0001, 9, 1, 8);
        load(32'h9999_9999, 1'b0);
        observe("pend", 32'h55, 24);

        // Raw non-BCD digits are stored unmodified.
        push_op(32'h0000_00AB, 0, 0, 0);
        load(32'h0000_00AB, 1'b0);
        observe("raw", 32'h0, 4);

        // Reset in the middle of a wrap carry.
        load(32'h9999_9999, 1'b0);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midcarry_busy", wr_ready, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("rst_hold");

        // Release with an immediate load, then watch the scan of 00000305.
        push_scan(32'h0000_0305, 8);
        push_op(32'h0000_0305, 0, 0, 0);
        rst_n = 1'b1;
        load(32'h0000_0305, 1'b0);
        observe("post_rst", 32'h0, 38);

        chk("scan_q_left", scan_q.size(), 32'd0);
        chk("op_q_left",   op_q.size(),   32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
